// File: rtl/fp_result_packer_if.sv
// Valid/ready streams between the FP adder result and the packer.
// Master drives results in and takes packed words out.
interface fp_result_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic        mode_fp;
  logic        res_sign;
  logic [7:0]  res_exp;
  logic [22:0] res_mant;
  logic        res_ovf;
  logic        res_unf;
  logic        res_inx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inx;

  modport master (
    output in_valid, mode_fp, res_sign,
    output res_exp, res_mant,
    output res_ovf, res_unf, res_inx,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  out_ovf, out_unf, out_inx
  );

  modport slave (
    input  in_valid, mode_fp, res_sign,
    input  res_exp, res_mant,
    input  res_ovf, res_unf, res_inx,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output out_ovf, out_unf, out_inx
  );
endinterface

// File: rtl/fp_result_packer.sv
// FP result packer: SP/HP IEEE-754 packing, 2-entry skid, sticky flags.
// FP_PACK_NAN_EN: exp==255 with nonzero mantissa packs as quiet NaN.
module fp_result_packer #(
  parameter bit HP_ROUND = 1'b1
) (
  input  logic clk,
  input  logic rst,
  fp_result_packer_if.slave bus,
  input  logic clr_flags,
  output logic sticky_ovf,
  output logic sticky_unf,
  output logic sticky_inx
);

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    logic        inx;
  } word_t;

  word_t       pk;
  word_t       mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic        in_ready_q;
  logic        push;
  logic        pop;
  logic [2:0]  sticky;
  logic        g;
  logic        s;
  logic        inc;
  logic [10:0] m11;
  logic [5:0]  e6;

  logic        sg;
  logic [7:0]  ex;
  logic [22:0] mt;
  assign sg = bus.res_sign;
  assign ex = bus.res_exp;
  assign mt = bus.res_mant;

  always_comb begin
    g   = mt[12];
    s   = |mt[11:0];
    inc = HP_ROUND & g & (s | mt[13]);
    m11 = {1'b0, mt[22:13]} + {10'd0, inc};
    // low 5 bits of exp-112 are exact over 113..142
    e6  = {1'b0, ex[4:0] - 5'd16}
        + {5'd0, m11[10]};
    pk      = '0;
    pk.ovf  = bus.res_ovf;
    pk.unf  = bus.res_unf;
    pk.inx  = bus.res_inx;
    if (bus.mode_fp) begin
      pk.data = {sg, ex, mt};
      if (ex == 8'hFF) begin
`ifdef FP_PACK_NAN_EN
        if (|mt) begin
          pk.data = {sg, 8'hFF, mt | 23'h400000};
          pk.ovf  = 1'b0;
        end else begin
          pk.data = {sg, 8'hFF, 23'd0};
        end
`else
        pk.data = {sg, 8'hFF, 23'd0};
`endif
      end
    end else if (ex == 8'd0) begin
      pk.data = {16'd0, sg, 15'd0};
`ifdef FP_PACK_NAN_EN
    end else if (ex == 8'hFF && |mt) begin
      pk.data = {16'd0, sg, 5'h1F, 10'h200};
      pk.ovf  = 1'b0;
`endif
    end else if (ex == 8'hFF || bus.res_ovf) begin
      pk.data = {16'd0, sg, 5'h1F, 10'd0};
      pk.ovf  = 1'b1;
    end else if (ex <= 8'd112) begin
      pk.data = {16'd0, sg, 15'd0};
      pk.unf  = 1'b1;
      pk.inx  = 1'b1;
    end else if (ex >= 8'd143) begin
      pk.data = {16'd0, sg, 5'h1F, 10'd0};
      pk.ovf  = 1'b1;
      pk.inx  = 1'b1;
    end else begin
      pk.inx = bus.res_inx | g | s;
      if (e6 == 6'd31) begin
        pk.data = {16'd0, sg, 5'h1F, 10'd0};
        pk.ovf  = 1'b1;
      end else begin
        pk.data = {16'd0, sg, e6[4:0], m11[9:0]};
      end
    end
  end

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (count != 2'd0) & bus.out_ready;

  always_comb begin
    count_nxt = count;
    if (push & ~pop)
      count_nxt = count + 2'd1;
    else if (pop & ~push)
      count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b1;
      sticky     <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pk;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count      <= count_nxt;
      in_ready_q <= (count_nxt != 2'd2);
      // clear first so a same-cycle word still lands
      if (clr_flags)
        sticky <= push ? {pk.ovf, pk.unf, pk.inx}
                       : 3'd0;
      else if (push)
        sticky <= sticky
                | {pk.ovf, pk.unf, pk.inx};
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = mem[rd_ptr].data;
  assign bus.out_ovf   = mem[rd_ptr].ovf;
  assign bus.out_unf   = mem[rd_ptr].unf;
  assign bus.out_inx   = mem[rd_ptr].inx;

  assign sticky_ovf = sticky[2];
  assign sticky_unf = sticky[1];
  assign sticky_inx = sticky[0];

endmodule

// File: tb/tb_fp_result_packer.sv
// Directed bench for fp_result_packer with a scoreboard queue.
// Word layout in checks: {data[31:0], ovf, unf, inx}.
module tb_fp_result_packer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_flags = 1'b0;
  logic clr2 = 1'b0;
  logic st_ovf, st_unf, st_inx;
  logic t_ovf, t_unf, t_inx;

  int passed = 0;
  int total  = 0;
  logic [34:0] sb [$];

  fp_result_packer_if bus ();
  fp_result_packer_if bus2 ();

  fp_result_packer #(.HP_ROUND(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .clr_flags(clr_flags),
    .sticky_ovf(st_ovf),
    .sticky_unf(st_unf),
    .sticky_inx(st_inx)
  );

  fp_result_packer #(.HP_ROUND(1'b0)) u_trunc (
    .clk(clk), .rst(rst), .bus(bus2),
    .clr_flags(clr2),
    .sticky_ovf(t_ovf),
    .sticky_unf(t_unf),
    .sticky_inx(t_inx)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.mode_fp   = bus.mode_fp;
  assign bus2.res_sign  = bus.res_sign;
  assign bus2.res_exp   = bus.res_exp;
  assign bus2.res_mant  = bus.res_mant;
  assign bus2.res_ovf   = bus.res_ovf;
  assign bus2.res_unf   = bus.res_unf;
  assign bus2.res_inx   = bus.res_inx;
  assign bus2.out_ready = 1'b1;

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [34:0] obs,
                       input logic [34:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      check("sb_nonempty",
            35'(sb.size() != 0), 35'd1);
      if (sb.size() != 0)
        check("out_word",
              {bus.out_data, bus.out_ovf,
               bus.out_unf, bus.out_inx},
              sb.pop_front());
    end
  end

  task automatic drive(input bit md, input bit sn,
                       input logic [7:0] e,
                       input logic [22:0] m,
                       input bit fo, input bit fu,
                       input bit fi, input bit clr,
                       input logic [34:0] expw);
    sb.push_back(expw);
    bus.in_valid = 1'b1;
    bus.mode_fp  = md;
    bus.res_sign = sn;
    bus.res_exp  = e;
    bus.res_mant = m;
    bus.res_ovf  = fo;
    bus.res_unf  = fu;
    bus.res_inx  = fi;
    clr_flags    = clr;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100)
      check("accept_timeout", 35'd1, 35'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    clr_flags    = 1'b0;
  endtask

  task automatic send(input bit md, input bit sn,
                      input logic [7:0] e,
                      input logic [22:0] m,
                      input bit fi, input bit clr,
                      input logic [34:0] expw);
    drive(md, sn, e, m, 1'b0, 1'b0, fi, clr, expw);
    wait_accept();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mode_fp   = 1'b0;
    bus.res_sign  = 1'b0;
    bus.res_exp   = 8'd0;
    bus.res_mant  = 23'd0;
    bus.res_ovf   = 1'b0;
    bus.res_unf   = 1'b0;
    bus.res_inx   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 35'(bus.out_valid), 35'd0);
    check("rst_in_ready", 35'(bus.in_ready), 35'd1);
    check("rst_out_word",
          {bus.out_data, bus.out_ovf,
           bus.out_unf, bus.out_inx}, 35'd0);
    check("rst_sticky",
          {32'd0, st_ovf, st_unf, st_inx}, 35'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // SP pass-through with one-cycle latency
    send(1, 0, 8'h80, 23'h400000, 0, 0,
         {32'h40400000, 3'b000});
    check("sp_latency", 35'(bus.out_valid), 35'd1);

    // HP normal, rounding and range
    send(0, 0, 8'h7F, 23'h0, 0, 0,
         {32'h00003C00, 3'b000});
    send(0, 0, 8'h7F, 23'h003000, 0, 0,
         {32'h00003C02, 3'b001});
    check("trunc_3c01",
          {bus2.out_data, 2'b00, bus2.out_valid},
          {32'h00003C01, 3'b001});
    send(0, 0, 8'h7F, 23'h001000, 0, 0,
         {32'h00003C00, 3'b001});
    send(0, 0, 8'h8F, 23'h0, 0, 0,
         {32'h00007C00, 3'b101});
    send(0, 0, 8'h70, 23'h0, 0, 0,
         {32'h00000000, 3'b011});
    send(0, 0, 8'h8E, 23'h7FF000, 0, 0,
         {32'h00007C00, 3'b101});
    send(0, 1, 8'h00, 23'h123, 1, 0,
         {32'h00008000, 3'b001});
    send(0, 1, 8'hFF, 23'h0, 0, 0,
         {32'h0000FC00, 3'b100});
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: two fill the buffer, third waits
    bus.out_ready = 1'b0;
    send(0, 0, 8'h7F, 23'h0, 0, 0,
         {32'h00003C00, 3'b000});
    send(0, 0, 8'h7F, 23'h003000, 0, 0,
         {32'h00003C02, 3'b001});
    drive(1, 1, 8'h81, 23'h200000, 0, 0, 0, 0,
          {32'hC0A00000, 3'b000});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 35'(bus.in_ready), 35'd0);
      check("bp_head",
            {bus.out_data, 2'b00, bus.out_valid},
            {32'h00003C00, 3'b001});
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_accept();
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", 35'(sb.size()), 35'd0);
    check("bp_empty", 35'(bus.out_valid), 35'd0);

    // Sticky flags with same-cycle clear
    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    clr_flags = 1'b0;
    check("stk_cleared",
          {32'd0, st_ovf, st_unf, st_inx}, 35'd0);
    send(0, 0, 8'h8F, 23'h0, 0, 0,
         {32'h00007C00, 3'b101});
    check("stk_ovf", 35'(st_ovf), 35'd1);
    send(0, 0, 8'h7F, 23'h001000, 0, 1,
         {32'h00003C00, 3'b001});
    check("stk_after_clr",
          {32'd0, st_ovf, st_unf, st_inx},
          {32'd0, 3'b001});
    repeat (3) @(posedge clk);
    #1;

    // Reset with two words buffered
    bus.out_ready = 1'b0;
    send(0, 0, 8'h7F, 23'h0, 0, 0,
         {32'h00003C00, 3'b000});
    send(1, 0, 8'h80, 23'h400000, 0, 0,
         {32'h40400000, 3'b000});
    check("pre_rst_full", 35'(bus.in_ready), 35'd0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_drop_valid", 35'(bus.out_valid), 35'd0);
    sb.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 35'(bus.in_ready), 35'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale", 35'(bus.out_valid), 35'd0);
    end
    check("post_rst_sticky",
          {32'd0, st_ovf, st_unf, st_inx}, 35'd0);

    // Stream resumes normally after reset
    @(posedge clk);
    #1;
    send(0, 0, 8'h80, 23'h0, 0, 0,
         {32'h00004000, 3'b000});
    repeat (3) @(posedge clk);
    #1;
    check("final_drain", 35'(sb.size()), 35'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fp_result_packer.md
Name: fp_result_packer

Overview:
- Downstream stage of the FP adder/subtractor. Consumes its unpacked result: sign, 8-bit SP-biased exponent, 23-bit mantissa, overflow/underflow/inexact flags and mode_fp.
- Produces a packed IEEE-754 word, 32-bit single or 16-bit half in bits [15:0], on a valid/ready stream.
- For half precision it narrows the result: rebias the exponent, round the mantissa to 10 bits, clamp to inf or zero.
- Holds a 2-entry skid buffer and a sticky exception-flag register readable by the control/CSR logic.

Parameters:
- HP_ROUND, 1, half-precision mantissa narrowing: 1 = round-to-nearest-even, 0 = truncate.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  packer can accept this cycle.
- mode_fp  input  1  0 = half, 1 = single.
- res_sign  input  1  result sign.
- res_exp  input  8  result exponent, SP bias 127.
- res_mant  input  23  result fraction, no hidden bit.
- res_ovf, res_unf, res_inx  input  1 each  upstream exception flags.
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  32  packed word; HP mode zero-fills [31:16].
- out_ovf, out_unf, out_inx  output  1 each  final per-word flags, aligned with out_data.
- clr_flags  input  1  one-cycle pulse, clears sticky flags.
- sticky_ovf, sticky_unf, sticky_inx  output  1 each  accumulated flags.

Behaviour:
- Reset (rst low, async): buffer empty, out_valid=0, in_ready=1, out_data=0, all out_* and sticky_* flags 0.
- Handshake: accept when in_valid&in_ready. Transfer when out_valid&out_ready. Inputs are sampled only on accept.
- Buffer: 2 entries, FIFO order.
- in_ready = (count<2), registered.
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Full buffer with simultaneous pop: in_ready is 0 that cycle; the accept is deferred, never dropped.
- Simultaneous push and pop at count=1: count stays 1, order is preserved.
- SP packing: out_data = {sign, exp, mant}. Flags pass through unchanged.
- HP packing, evaluated in priority order:
  - exp==0: signed zero {sign,15'b0}. Flags pass through.
  - exp==255 or res_ovf: inf {sign,5'h1F,10'b0}, ovf=1.
  - exp<=112: signed zero, unf=1, inx=1.
  - exp>=143: inf, ovf=1, inx=1.
  - Otherwise e5 = exp-112 and m10 = mant[22:13], g = mant[12], s = |mant[11:0].
  - HP_ROUND=1: increment when g&(s|m10[0]). On carry-out, m10=0 and e5+1; if e5 becomes 31 the result is inf and ovf=1.
  - inx = res_inx | g | s.
- Sticky flags: on accept, sticky_x |= final flag x.
- clr_flags in the same cycle as an accept: clear is applied first, then that word's flags are set.
- Reset mid-stream: buffer contents discarded, no partial word is emitted.

Optional Feature:
- FP_PACK_NAN_EN defined: exp==255 with mant!=0 emits quiet NaN. SP: {sign,8'hFF,mant|23'h400000}. HP: {sign,5'h1F,10'h200}. No ovf is raised for NaN.
- Undefined: every exp==255 input packs as infinity per the rules above, mantissa discarded.

Test Plan:
- SP pass-through: mode_fp=1, sign 0, exp 0x80, mant 0x400000 -> out_data 0x40400000 one cycle later, flags 0.
- HP normal and rounding: mode_fp=0, exp 0x7F, mant 0 -> 0x00003C00.
  - mant 0x003000 -> 0x00003C02, inx=1.
  - mant 0x001000 -> 0x00003C00, inx=1.
  - With HP_ROUND=0, mant 0x003000 -> 0x00003C01.
- HP range: exp 0x8F -> 0x00007C00, ovf=1. exp 0x70 -> 0x00000000, unf=1. exp 0x8E, mant 0x7FF000 -> 0x00007C00, ovf=1.
- Backpressure: out_ready=0 and three back-to-back inputs -> two accepted, in_ready=0, third held. Raise out_ready -> all three emerge in order, no duplicates.
- Sticky flags: overflow word, then clr_flags in the same cycle as an inexact word -> sticky_ovf=0, sticky_inx=1.
- Reset: assert rst with 2 words buffered -> out_valid drops immediately; after release, in_ready=1 and no stale word appears.
